// File: rtl/axis_pkt_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_gen_pkg
// Description : Shared types and constants for the AXI-Stream packet
//               generator: FSM state encoding, default widths and the
//               beat/data increment step.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pkt_gen_pkg;

  // Generator FSM states; GAP is only reachable when inter-packet gaps
  // are compiled in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int C_DEF_DATA_WIDTH = 16;
  localparam int C_DEF_LEN_WIDTH  = 16;
  localparam int C_DEF_CNT_WIDTH  = 16;
  localparam int C_DEF_GAP_WIDTH  = 8;

  // Step applied to the data pattern, beat index and packet counter.
  localparam int C_BEAT_INC = 1;

endpackage : axis_pkt_gen_pkg
`default_nettype wire

// File: rtl/axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_gen
// Description : AXI-Stream packet transmitter. On a start pulse emits
//               pkt_count packets of pkt_len beats carrying an incrementing
//               data pattern from seed, with TLAST on each packet's final
//               beat, under full downstream backpressure.
//               Optional macro AXIS_PKT_GEN_GAP_EN adds the gap_cycles input
//               and a GAP state that idles the stream between packets.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
`ifdef AXIS_PKT_GEN_GAP_EN
  parameter int P_GAP_WIDTH  = C_DEF_GAP_WIDTH,
`endif
  parameter int P_DATA_WIDTH = C_DEF_DATA_WIDTH,
  parameter int P_LEN_WIDTH  = C_DEF_LEN_WIDTH,
  parameter int P_CNT_WIDTH  = C_DEF_CNT_WIDTH
) (
`ifdef AXIS_PKT_GEN_GAP_EN
  input  logic [P_GAP_WIDTH-1:0]  gap_cycles,
`endif
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [P_LEN_WIDTH-1:0]  pkt_len,
  input  logic [P_CNT_WIDTH-1:0]  pkt_count,
  input  logic [P_DATA_WIDTH-1:0] seed,
  output logic                    busy,
  output logic                    done,
  output logic [P_CNT_WIDTH-1:0]  pkts_sent,
  output logic                    M_AXIS_T_VALID,
  input  logic                    M_AXIS_T_READY,
  output logic [P_DATA_WIDTH-1:0] M_AXIS_T_DATA,
  output logic                    M_AXIS_T_LAST
);

  state_t                  r_state;
  state_t                  w_next_state;

  logic [P_LEN_WIDTH-1:0]  r_len;
  logic [P_CNT_WIDTH-1:0]  r_count;
  logic [P_DATA_WIDTH-1:0] r_data;
  logic [P_LEN_WIDTH-1:0]  r_beat;
  logic [P_CNT_WIDTH-1:0]  r_pkts;

`ifdef AXIS_PKT_GEN_GAP_EN
  logic [P_GAP_WIDTH-1:0]  r_gap;
  logic [P_GAP_WIDTH-1:0]  r_gap_cnt;
`endif

  logic                    w_xfer;
  logic                    w_last_beat;
  logic [P_CNT_WIDTH-1:0]  w_pkts_inc;
  logic                    w_final_pkt;
  logic                    w_empty_run;

  // Transfer qualifiers; VALID comes purely from state, so READY never
  // feeds back into VALID. pkt_len-1 is only meaningful for pkt_len>=1,
  // which SEND guarantees.
  assign w_xfer      = (r_state == ST_SEND) && M_AXIS_T_READY;
  assign w_last_beat = (r_beat == (r_len - P_LEN_WIDTH'(C_BEAT_INC)));
  assign w_pkts_inc  = r_pkts + P_CNT_WIDTH'(C_BEAT_INC);
  assign w_final_pkt = (w_pkts_inc == r_count);
  assign w_empty_run = (pkt_len == '0) || (pkt_count == '0);

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = w_empty_run ? ST_DONE : ST_SEND;
      end
      ST_SEND: begin
        if (w_xfer && w_last_beat) begin
          if (w_final_pkt) begin
            w_next_state = ST_DONE;
          end else begin
`ifdef AXIS_PKT_GEN_GAP_EN
            w_next_state = (r_gap != '0) ? ST_GAP : ST_SEND;
`else
            w_next_state = ST_SEND;
`endif
          end
        end
      end
      ST_GAP: begin
`ifdef AXIS_PKT_GEN_GAP_EN
        if (r_gap_cnt == '0) w_next_state = ST_SEND;
`else
        w_next_state = ST_IDLE;
`endif
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Run parameters, data pattern, beat index and packet counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_beat  <= '0;
      r_pkts  <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_len   <= pkt_len;
        r_count <= pkt_count;
        r_data  <= seed;
        r_beat  <= '0;
        r_pkts  <= '0;
      end else if (w_xfer) begin
        // Pattern runs continuously across packet boundaries.
        r_data <= r_data + P_DATA_WIDTH'(C_BEAT_INC);
        if (w_last_beat) begin
          r_beat <= '0;
          r_pkts <= w_pkts_inc;
        end else begin
          r_beat <= r_beat + P_LEN_WIDTH'(C_BEAT_INC);
        end
      end
    end
  end

`ifdef AXIS_PKT_GEN_GAP_EN
  // Gap length latch and countdown; loading gap-1 yields exactly gap
  // cycles in GAP before returning to SEND.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gap     <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_gap <= gap_cycles;
      end
      if (w_xfer && w_last_beat) begin
        r_gap_cnt <= r_gap - P_GAP_WIDTH'(C_BEAT_INC);
      end else if (r_state == ST_GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - P_GAP_WIDTH'(C_BEAT_INC);
      end
    end
  end
`endif

  assign M_AXIS_T_VALID = (r_state == ST_SEND);
  assign M_AXIS_T_LAST  = (r_state == ST_SEND) && w_last_beat;
  assign M_AXIS_T_DATA  = r_data;
  assign busy           = (r_state == ST_SEND) || (r_state == ST_GAP);
  assign done           = (r_state == ST_DONE);
  assign pkts_sent      = r_pkts;

endmodule : axis_pkt_gen
`default_nettype wire

// File: doc/axis_pkt_gen.md
Name: axis_pkt_gen

Overview:
AXI-Stream packet transmitter that sources framed traffic into stream sinks such as the sync FIFO slave port.
- On a start pulse, emits pkt_count packets of pkt_len beats each.
- Payload is an incrementing data pattern from a seed; TLAST marks the final beat of each packet.
- Fully honours downstream backpressure.
- Used as a bench/bring-up stimulus source and as an on-chip traffic generator.

Parameters:
P_DATA_WIDTH, 16, width of M_AXIS_T_DATA and seed
P_LEN_WIDTH, 16, width of pkt_len (beats per packet)
P_CNT_WIDTH, 16, width of pkt_count and pkts_sent
P_GAP_WIDTH, 8, width of gap_cycles (optional feature only)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
start  in  1  single-cycle request; sampled only in IDLE
pkt_len  in  P_LEN_WIDTH  beats per packet; latched on accepted start
pkt_count  in  P_CNT_WIDTH  packets per run; latched on accepted start
seed  in  P_DATA_WIDTH  first data word of the run; latched on accepted start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse when run completes
pkts_sent  out  P_CNT_WIDTH  packets fully accepted in current/last run
M_AXIS_T_VALID  out  1  stream valid
M_AXIS_T_READY  in  1  stream ready from sink
M_AXIS_T_DATA  out  P_DATA_WIDTH  stream data
M_AXIS_T_LAST  out  1  last beat of packet

Behaviour:
- Reset (rst==0 sampled at edge): state=IDLE; VALID, LAST, busy and done=0; DATA=0; pkts_sent=0.
  - Reset mid-run aborts immediately; VALID is low the cycle after reset is sampled. No partial-packet completion.
- Transfer: a beat transfers when VALID & READY at a clock edge.
- States: IDLE, SEND, GAP (feature only), DONE.
- IDLE: when start==1, latch pkt_len, pkt_count and seed; clear pkts_sent and the beat index.
  - If pkt_len==0 or pkt_count==0, go to DONE; no beats are emitted.
  - Otherwise go to SEND. VALID rises the cycle after start (latency 1), with DATA=seed.
- SEND:
  - VALID=1 continuously.
  - DATA and LAST are held stable until transfer; VALID never deasserts without a transfer.
  - VALID does not depend combinationally on READY.
  - On each transfer, DATA increments by 1 modulo 2^P_DATA_WIDTH (e.g. 0xFFFF->0x0000). The pattern continues across packet boundaries; it does not restart at seed.
  - LAST=1 exactly on the beat where beat index == pkt_len-1. On the transfer of that beat, the beat index resets to 0 and pkts_sent increments.
  - If that packet was number pkt_count, go to DONE. Otherwise start the next packet with no bubble (VALID stays 1), or go to GAP when the feature is enabled.
- DONE: done=1 and busy=0 for one cycle; VALID=0; then IDLE.
- busy=1 in SEND/GAP, 0 in IDLE/DONE.
- start is ignored outside IDLE. Inputs pkt_len, pkt_count and seed may change freely after latch.
- Counters: beat index is P_LEN_WIDTH wide; pkts_sent is P_CNT_WIDTH wide. No overflow is possible, since both are bounded by the latched values.
- pkts_sent holds its final value in IDLE until the next accepted start.

Optional Feature:
AXIS_PKT_GEN_GAP_EN
- Defined:
  - Adds input port gap_cycles [P_GAP_WIDTH].
  - gap_cycles is latched on start.
  - After each non-final packet, the FSM spends exactly gap_cycles cycles in GAP with VALID=0, then returns to SEND.
  - gap_cycles==0 gives back-to-back packets, identical to the undefined case.
  - No gap occurs after the final packet.
- Undefined: gap_cycles port and GAP state absent; packets are always back-to-back.

Decomposition:
- Package axis_pkt_gen_pkg:
  - state enum (IDLE, SEND, GAP, DONE);
  - default width localparams;
  - beat-increment constant (1).
- No sub-module; FSM plus three counters (beat, packet, gap) fit in a single module.

Test Plan:
- Always-ready sink; pkt_len=4, pkt_count=2, seed=0x0010 → 8 consecutive beats 0x0010..0x0017 with no bubbles; LAST on 0x0013 and 0x0017; done pulse 1 cycle after last transfer; pkts_sent=2.
- Random READY (50%); pkt_len=3, pkt_count=3 → DATA/LAST stable whenever VALID&!READY; 9 beats delivered in order; VALID never drops mid-run.
- seed=0xFFFE, pkt_len=4, pkt_count=1 → DATA 0xFFFE, 0xFFFF, 0x0000, 0x0001; LAST on 0x0001.
- pkt_len=0, pkt_count=5 → VALID never asserts; done 1 cycle after start; pkts_sent=0. Repeat with pkt_len=1, pkt_count=3 → every beat has LAST=1.
- rst=0 asserted after 2 of 5 beats while READY=0 → VALID=0 next cycle; busy=0; pkts_sent=0; no done pulse. New start afterwards runs cleanly from its seed. A start during busy is ignored.
- With AXIS_PKT_GEN_GAP_EN, gap_cycles=3, pkt_len=2, pkt_count=2 → exactly 3 VALID=0 cycles between the packets; none after the last. With gap_cycles=0 → back-to-back.
